// File: rtl/simon_sequencer.sv
// simon_sequencer: Simon round controller; grows a random colour sequence, plays it back, checks player presses.
// Latency: start -> APPEND next cycle, lamp trails PLAY_ON by one cycle, win/game_over set on the deciding edge.
// Backpressure: none; presses outside WAIT_INPUT are dropped. SIMON_SPEEDUP_EN shortens on-time as level grows.
module simon_sequencer #(
    parameter int         MAX_LEN       = 16,
    parameter int         ON_TICKS      = 30,
    parameter int         OFF_TICKS     = 30,
    parameter int         TIMEOUT_TICKS = 120,
    parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [1:0]                   player_num,
    input  logic                         player_pressed,
    output logic                         simon_turn,
    output logic [1:0]                   simon_num,
    output logic                         simon_pressed,
    output logic [$clog2(MAX_LEN+1)-1:0] level,
    output logic                         game_over,
    output logic                         win
);
    localparam int LW   = $clog2(MAX_LEN + 1);
    localparam int IW   = $clog2(MAX_LEN);
    localparam int TM0  = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int TM1  = (TM0 > TIMEOUT_TICKS) ? TM0 : TIMEOUT_TICKS;
    localparam int TMAX = (TM1 > 8) ? TM1 : 8;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] OFF_LAST  = TW'(OFF_TICKS - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_TICKS - 1);
    localparam logic [LW-1:0] LEVEL_WIN = LW'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPEND,
        S_PLAY_ON,
        S_PLAY_OFF,
        S_WAIT_INPUT,
        S_OVER,
        S_WIN
    } state_t;

    state_t        state, state_d;
    logic [7:0]    lfsr;
    logic [1:0]    seq [MAX_LEN];
    logic [IW-1:0] idx, idx_d;
    logic [TW-1:0] tmr, tmr_d;
    logic [TW-1:0] on_last;
    logic [LW-1:0] level_d;
    logic          turn_d, over_d, win_d, seq_we;
    logic          last_idx;

    assign last_idx = (LW'(idx) == level - LW'(1));

`ifdef SIMON_SPEEDUP_EN
    localparam int OW = $clog2(ON_TICKS + 1);
    int            shrink;
    logic [OW-1:0] on_sat;
    logic [TW-1:0] on_time;

    // On-time drops by two ticks per level, floored at eight
    always_comb begin
        shrink  = 2 * (int'(level) - 1);
        on_sat  = (shrink >= ON_TICKS) ? '0 : OW'(ON_TICKS - shrink);
        on_time = (int'(on_sat) < 8) ? TW'(8) : TW'(on_sat);
        on_last = on_time - TW'(1);
    end
`else
    assign on_last = TW'(ON_TICKS - 1);
`endif

    always_comb begin
        state_d = state;
        idx_d   = idx;
        tmr_d   = tmr;
        level_d = level;
        turn_d  = simon_turn;
        over_d  = game_over;
        win_d   = win;
        seq_we  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_d = S_APPEND;
            end
            S_APPEND: begin
                seq_we  = 1'b1;
                level_d = level + LW'(1);
                idx_d   = '0;
                tmr_d   = '0;
                turn_d  = 1'b1;
                state_d = S_PLAY_ON;
            end
            S_PLAY_ON: begin
                if (tmr == on_last) begin
                    tmr_d   = '0;
                    state_d = S_PLAY_OFF;
                end else begin
                    tmr_d = tmr + TW'(1);
                end
            end
            S_PLAY_OFF: begin
                if (tmr == OFF_LAST) begin
                    tmr_d = '0;
                    if (last_idx) begin
                        idx_d   = '0;
                        turn_d  = 1'b0;
                        state_d = S_WAIT_INPUT;
                    end else begin
                        idx_d   = idx + IW'(1);
                        state_d = S_PLAY_ON;
                    end
                end else begin
                    tmr_d = tmr + TW'(1);
                end
            end
            S_WAIT_INPUT: begin
                // A press in the timeout cycle wins over the timeout
                if (player_pressed) begin
                    if (player_num != seq[idx]) begin
                        over_d  = 1'b1;
                        state_d = S_OVER;
                    end else if (last_idx) begin
                        if (level == LEVEL_WIN) begin
                            win_d   = 1'b1;
                            state_d = S_WIN;
                        end else begin
                            state_d = S_APPEND;
                        end
                    end else begin
                        idx_d = idx + IW'(1);
                        tmr_d = '0;
                    end
                end else if (tmr == TO_LAST) begin
                    over_d  = 1'b1;
                    state_d = S_OVER;
                end else begin
                    tmr_d = tmr + TW'(1);
                end
            end
            S_OVER, S_WIN: begin
                if (start) begin
                    over_d  = 1'b0;
                    win_d   = 1'b0;
                    level_d = '0;
                    state_d = S_APPEND;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            lfsr          <= LFSR_SEED;
            idx           <= '0;
            tmr           <= '0;
            level         <= '0;
            simon_turn    <= 1'b0;
            simon_num     <= 2'b00;
            simon_pressed <= 1'b0;
            game_over     <= 1'b0;
            win           <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) seq[i] <= 2'b00;
        end else begin
            state      <= state_d;
            lfsr       <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            idx        <= idx_d;
            tmr        <= tmr_d;
            level      <= level_d;
            simon_turn <= turn_d;
            game_over  <= over_d;
            win        <= win_d;
            // Lamp is registered from the current state, so it trails PLAY_ON by a cycle
            simon_pressed <= (state == S_PLAY_ON);
            if (state == S_PLAY_ON) simon_num <= seq[idx];
            if (seq_we) seq[level[IW-1:0]] <= lfsr[1:0];
        end
    end
endmodule

// File: doc/simon_sequencer.md
# simon_sequencer

Round controller for the Simon game. It owns the growing colour sequence: it appends one random colour per round, plays the whole sequence back through the Simon button/LED outputs with fixed on/off timing, then checks the player's presses one by one with a per-press timeout. It sits between the 60 Hz tick domain and the display/button logic, and replaces single-step turn handling with a full multi-round game.

## Interface
Parameters:
- `MAX_LEN`, 16: sequence length that wins the game; 2..32.
- `ON_TICKS`, 30: cycles each colour is shown during playback.
- `OFF_TICKS`, 30: gap cycles after each shown colour.
- `TIMEOUT_TICKS`, 120: cycles allowed between player presses.
- `LFSR_SEED`, 8'hA5: LFSR reset value; must be non-zero.

Ports:
- `clk`  in  1: game clock, 60 Hz tick.
- `reset`  in  1: asynchronous, active-low reset.
- `start`  in  1: starts a new game; sampled only in IDLE, OVER or WIN.
- `player_num`  in  2: colour the player pressed; valid with `player_pressed`.
- `player_pressed`  in  1: one-cycle press pulse.
- `simon_turn`  out  1: 1 while the sequence is being played back.
- `simon_num`  out  2: colour being shown.
- `simon_pressed`  out  1: 1 while `simon_num` is lit.
- `level`  out  $clog2(MAX_LEN+1): current sequence length.
- `game_over`  out  1: sticky loss flag.
- `win`  out  1: sticky win flag.

## Operation
- Storage: `MAX_LEN` x 2-bit register array `seq`, plus index `idx` and a shared tick counter `tmr`.
- Random source: 8-bit Fibonacci LFSR with taps 8,6,5,4. It advances every cycle in every state and never holds. The new colour is `lfsr[1:0]`.
- States and transitions:
  - IDLE: on `start`, go to APPEND.
  - APPEND, 1 cycle: `seq[level] <= lfsr[1:0]`, `level++`, `idx <= 0`, `tmr <= 0`, `simon_turn <= 1`, go to PLAY_ON.
  - PLAY_ON: `simon_num = seq[idx]` and `simon_pressed = 1` for exactly `ON_TICKS` cycles, then go to PLAY_OFF.
  - PLAY_OFF: `simon_pressed = 0` for `OFF_TICKS` cycles. Then, if `idx == level-1`, set `idx <= 0`, `simon_turn <= 0` and go to WAIT_INPUT. Otherwise `idx++` and go to PLAY_ON.
  - WAIT_INPUT, with `tmr` counting cycles since the last press:
    - If a press arrives with `player_num != seq[idx]`, go to OVER.
    - If the press matches and `idx < level-1`, set `idx++` and `tmr <= 0`.
    - If the press matches and `idx == level-1`, go to WIN when `level == MAX_LEN`, otherwise go to APPEND.
    - If no press arrives and `tmr == TIMEOUT_TICKS-1`, go to OVER.
  - OVER: `game_over = 1`. WIN: `win = 1`. In either state, `start` clears both flags, sets `level <= 0` and goes to APPEND.
- `start` is ignored in APPEND, PLAY_ON, PLAY_OFF and WAIT_INPUT.
- `player_pressed` is ignored outside WAIT_INPUT, so presses during playback are neither errors nor buffered.
- If a press and the timeout occur in the same cycle, the press is evaluated and the timeout is discarded.
- `simon_num` holds its last value when not lit.

## Timing
- All outputs are registered.
- Reset values: `simon_turn = 0`, `simon_num = 0`, `simon_pressed = 0`, `level = 0`, `game_over = 0`, `win = 0`, state IDLE, `lfsr = LFSR_SEED`, `seq` all zero.
- `start` sampled at edge k puts the block in APPEND during cycle k+1.
- `simon_pressed` rises at edge k+2 and is high for `ON_TICKS` cycles.
- Playback of a round of length L lasts L*(ON_TICKS+OFF_TICKS) cycles after APPEND.
- `simon_turn` falls on the same edge that enters WAIT_INPUT.
- Wrong press: `game_over` is 1 on the edge after the press cycle.
- Final correct press: APPEND on the next cycle, or `win` is 1 on the next edge.
- Reset asserted mid-game immediately forces every reset value. No state survives.

## Configuration
- `SIMON_SPEEDUP_EN`:
  - Defined: the effective on-time is `max(8, ON_TICKS - 2*(level-1))`, computed in a width of `$clog2(ON_TICKS+1)` bits with the subtraction saturating. `OFF_TICKS` is unchanged.
  - Undefined: the on-time is always `ON_TICKS` and no subtractor is built.

## Test plan
Bench parameters: `ON_TICKS=4`, `OFF_TICKS=2`, `TIMEOUT_TICKS=10`, `MAX_LEN=3`.
- Reset and idle: release reset and hold `start = 0` for 20 cycles -> all outputs stay 0 and `level = 0`.
- First round: pulse `start` -> `level = 1`; `simon_pressed` is high for 4 cycles starting 2 cycles after the start edge; `simon_num = seq[0]`; `simon_turn` falls after 6 cycles.
- Full win: mirror each played colour with a press 3 cycles into WAIT_INPUT -> `level` steps 1, 2, 3; after the third correct press `win = 1` and `simon_turn = 0`.
- Wrong colour: in round 2, press `player_num = seq[1]^2'b01` at `idx = 1` -> `game_over = 1` next edge; further presses change nothing.
- Timeout race: no press for 9 cycles -> still WAIT_INPUT; 10th cycle with no press -> `game_over = 1`. Repeat with a correct press on the 10th cycle -> no `game_over`.
- Restart and reset: `start` in OVER -> flags clear and `level = 1`; assert `reset = 0` mid-PLAY_ON -> all outputs are 0 immediately.
